// File: rtl/obi_mem_arbiter_pkg.sv
// Shared Lucid64 arbiter definitions: host IDs, default byte enables and sizing helper.
package obi_mem_arbiter_pkg;

  typedef enum logic {
    HOST_IMEM = 1'b0,
    HOST_DMEM = 1'b1
  } host_id_e;

  localparam logic [7:0] DEFAULT_BE = 8'hFF;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// OBI bus bundle for the two hosts and the shared memory; slave = arbiter side.
interface obi_mem_arbiter_if;
  logic        imem_req_i;
  logic [63:0] imem_addr_i;
  logic        imem_gnt_o;
  logic        imem_rvalid_o;
  logic [63:0] imem_rdata_o;
  logic        dmem_req_i;
  logic        dmem_we_i;
  logic [7:0]  dmem_be_i;
  logic [63:0] dmem_addr_i;
  logic [63:0] dmem_wdata_i;
  logic        dmem_gnt_o;
  logic        dmem_rvalid_o;
  logic [63:0] dmem_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  modport slave (
    input  imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_be_i, dmem_addr_i, dmem_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_be_i, dmem_addr_i, dmem_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/obi_mem_arbiter_owner_fifo.sv
// In-order FIFO of host IDs for granted transactions still awaiting rvalid.
module arb_owner_fifo
  import obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  host_id_e id_i,
  output logic     full_o,
  output logic     empty_o,
  output host_id_e head_o
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] own_q, own_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign head_o    = host_id_e'(own_q[rd_ptr_q]);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    own_d    = own_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      own_d[wr_ptr_q] = id_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      own_q    <= own_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-host OBI arbiter onto one memory port; define LUCID64_ARB_ROUND_ROBIN_EN for
// round-robin contention, otherwise dmem has fixed priority.
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  obi_mem_arbiter_if.slave   bus,
  output logic               err_o
);

  host_id_e sel_s, favour_s, head_s, lock_id_q, lock_id_d;
  logic     lock_q, lock_d, err_q, err_d;
  logic     req_sel_s, mem_req_s, push_s, pop_s, full_s, empty_s;
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
  host_id_e rr_q, rr_d;
`endif

  // Winner selection: a pending ungranted request keeps its host until mem_gnt_i.
  always_comb begin
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
    favour_s = rr_q;
`else
    favour_s = HOST_DMEM;
`endif
    if (lock_q) begin
      sel_s = lock_id_q;
    end else if (bus.imem_req_i && bus.dmem_req_i) begin
      sel_s = favour_s;
    end else if (bus.dmem_req_i) begin
      sel_s = HOST_DMEM;
    end else begin
      sel_s = HOST_IMEM;
    end
    req_sel_s = (sel_s == HOST_DMEM) ? bus.dmem_req_i : bus.imem_req_i;
    mem_req_s = req_sel_s & ~full_s;
    push_s    = mem_req_s & bus.mem_gnt_i;
    pop_s     = bus.mem_rvalid_i & ~empty_s;
    lock_d    = mem_req_s & ~bus.mem_gnt_i;
    lock_id_d = sel_s;
    err_d     = err_q | (bus.mem_rvalid_i & empty_s);
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
    if (push_s && (sel_s == rr_q)) begin
      rr_d = host_id_e'(~rr_q);
    end else begin
      rr_d = rr_q;
    end
`endif
  end

  // Request payload is zeroed whenever nothing is presented to memory.
  always_comb begin
    if (!mem_req_s) begin
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = 8'h00;
      bus.mem_addr_o  = 64'h0;
      bus.mem_wdata_o = 64'h0;
    end else if (sel_s == HOST_DMEM) begin
      bus.mem_we_o    = bus.dmem_we_i;
      bus.mem_be_o    = bus.dmem_be_i;
      bus.mem_addr_o  = bus.dmem_addr_i;
      bus.mem_wdata_o = bus.dmem_wdata_i;
    end else begin
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = DEFAULT_BE;
      bus.mem_addr_o  = bus.imem_addr_i;
      bus.mem_wdata_o = 64'h0;
    end
  end

  assign bus.mem_req_o     = mem_req_s;
  assign bus.imem_gnt_o    = push_s & (sel_s == HOST_IMEM);
  assign bus.dmem_gnt_o    = push_s & (sel_s == HOST_DMEM);
  assign bus.imem_rvalid_o = pop_s & (head_s == HOST_IMEM);
  assign bus.dmem_rvalid_o = pop_s & (head_s == HOST_DMEM);
  assign bus.imem_rdata_o  = bus.mem_rdata_i;
  assign bus.dmem_rdata_o  = bus.mem_rdata_i;
  assign err_o             = err_q;

  arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_s),
    .pop_i  (pop_s),
    .id_i   (sel_s),
    .full_o (full_s),
    .empty_o(empty_s),
    .head_o (head_s)
  );

  // Lock, sticky error and (optionally) round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= HOST_IMEM;
      err_q     <= 1'b0;
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
      rr_q      <= HOST_DMEM;
`endif
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: vector table plus hand-written corner sequences,
// with a queue scoreboard checking rvalid routing.
module tb_obi_mem_arbiter;

  localparam logic [63:0] IA = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DA = 64'h0000_0000_0000_1000;
  localparam logic [63:0] DW = 64'h0000_0000_CAFE_F00D;
  localparam logic [7:0]  DB = 8'h0F;

  logic clk;
  logic rst_n;
  logic err;
  int   n_cmp;
  int   n_bad;
  logic sb_q[$];

  obi_mem_arbiter_if bus();

  obi_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ir, dr, g, rv;
    logic mreq, dsel, ig, dg;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv,
                       input logic [63:0] rd);
    @(negedge clk);
    bus.imem_req_i   = ir;
    bus.dmem_req_i   = dr;
    bus.mem_gnt_i    = g;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rd;
    #1;
  endtask

  task automatic sb_rvalid(input string nm);
    logic ei, ed, e;
    ei = 1'b0;
    ed = 1'b0;
    if (bus.mem_rvalid_i && sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      ei = (e == 1'b0);
      ed = (e == 1'b1);
    end
    chk({nm, "_irvalid"}, bus.imem_rvalid_o, ei);
    chk({nm, "_drvalid"}, bus.dmem_rvalid_o, ed);
  endtask

  task automatic expect_bus(input string nm, input logic mreq, input logic dsel,
                            input logic ig, input logic dg);
    chk({nm, "_mreq"}, bus.mem_req_o, mreq);
    if (mreq) begin
      chk({nm, "_addr"},  bus.mem_addr_o,  dsel ? DA : IA);
      chk({nm, "_we"},    bus.mem_we_o,    dsel ? 1'b1 : 1'b0);
      chk({nm, "_be"},    bus.mem_be_o,    dsel ? DB : 8'hFF);
      chk({nm, "_wdata"}, bus.mem_wdata_o, dsel ? DW : 64'h0);
    end
    chk({nm, "_igT"}, bus.imem_gnt_o, ig);
    chk({nm, "_dgnt"}, bus.dmem_gnt_o, dg);
    if (ig) sb_q.push_back(1'b0);
    if (dg) sb_q.push_back(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.imem_req_i   = 1'b0;
    bus.dmem_req_i   = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 64'h0;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_err",   err,               64'h0);
    chk("rst_mreq",  bus.mem_req_o,     64'h0);
    chk("rst_addr",  bus.mem_addr_o,    64'h0);
    chk("rst_be",    bus.mem_be_o,      64'h0);
    chk("rst_gnts",  {bus.imem_gnt_o, bus.dmem_gnt_o}, 64'h0);
    chk("rst_rvld",  {bus.imem_rvalid_o, bus.dmem_rvalid_o}, 64'h0);
    chk("rst_rdata", bus.imem_rdata_o | bus.dmem_rdata_o, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] grant_d;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.imem_addr_i  = IA;
    bus.dmem_addr_i  = DA;
    bus.dmem_we_i    = 1'b1;
    bus.dmem_be_i    = DB;
    bus.dmem_wdata_i = DW;
    do_reset();

    //        ir    dr    g     rv    mreq  dsel  ig    dg
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].g, tbl[i].rv, 64'h100 + 64'(i));
      sb_rvalid($sformatf("vec%0d", i));
      expect_bus($sformatf("vec%0d", i), tbl[i].mreq, tbl[i].dsel, tbl[i].ig, tbl[i].dg);
      chk($sformatf("vec%0d_err", i), err, 64'h0);
      chk($sformatf("vec%0d_rdata", i), bus.dmem_rdata_o, 64'h100 + 64'(i));
    end

    // Stray rvalid in the last row must leave a sticky error until reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      chk("err_sticky", err, 64'h1);
    end
    do_reset();

    // Single imem read, data two cycles after grant.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    expect_bus("ird", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h13);
    sb_rvalid("ird");
    chk("ird_rdata", bus.imem_rdata_o, 64'h13);

    // Contention with immediate grant: D then I, responses in order.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    expect_bus("cont0", 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    expect_bus("cont1", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hD0);
    sb_rvalid("cont_r0");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hA0);
    sb_rvalid("cont_r1");

    // Continuous contention, four grants.
`ifdef LUCID64_ARB_ROUND_ROBIN_EN
    grant_d = 4'b0101;
`else
    grant_d = 4'b1111;
`endif
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, (k > 0), 64'h0);
      sb_rvalid($sformatf("arb%0d", k));
      expect_bus($sformatf("arb%0d", k), 1'b1, grant_d[k], ~grant_d[k], grant_d[k]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    sb_rvalid("arb_drain");

    // Stalled imem request holds the bus while dmem waits.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    expect_bus("lock0", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      expect_bus($sformatf("lock%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    expect_bus("lock3", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    expect_bus("lock4", 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    sb_rvalid("lock_r0");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    sb_rvalid("lock_r1");
    chk("lock_noerr", err, 64'h0);

    // Reset with a transaction outstanding; the late rvalid is a stray.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    expect_bus("mid", 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h55);
    sb_rvalid("late");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("late_err", err, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2, setting the maximum number of granted transactions awaiting rvalid (legal range 1..4).
REQ-002 The block SHALL have these ports, one per line:
- clk_i  input  1  sole clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- imem_req_i  input  1  instruction host request.
- imem_addr_i  input  64  instruction host address.
- imem_gnt_o  output  1  instruction host grant.
- imem_rvalid_o  output  1  instruction host response valid.
- imem_rdata_o  output  64  instruction host read data.
- dmem_req_i  input  1  data host request.
- dmem_we_i  input  1  data host write enable.
- dmem_be_i  input  8  data host byte enables.
- dmem_addr_i  input  64  data host address.
- dmem_wdata_i  input  64  data host write data.
- dmem_gnt_o  output  1  data host grant.
- dmem_rvalid_o  output  1  data host response valid.
- dmem_rdata_o  output  64  data host read data.
- mem_req_o  output  1  shared memory request.
- mem_we_o  output  1  shared memory write enable.
- mem_be_o  output  8  shared memory byte enables.
- mem_addr_o  output  64  shared memory address.
- mem_wdata_o  output  64  shared memory write data.
- mem_gnt_i  input  1  shared memory grant.
- mem_rvalid_i  input  1  shared memory response valid.
- mem_rdata_i  input  64  shared memory read data.
- err_o  output  1  sticky protocol-error flag.

Function
REQ-003 The block SHALL forward the winning host's request to mem_* combinationally (zero added request latency); the imem path SHALL drive we=0, be=8'hFF, wdata=0.
REQ-004 The host's gnt SHALL equal mem_gnt_i AND (that host selected) AND mem_req_o; the losing host's gnt SHALL be 0.
REQ-005 The winner SHALL be locked from the first cycle its request is presented to memory until mem_gnt_i; no host switch while mem_req_o=1 and mem_gnt_i=0.
REQ-006 When unlocked and both requests are asserted, the winner SHALL follow the arbitration policy (REQ-015/016); a lone requester SHALL always win.
REQ-007 Each accepted handshake (mem_req_o and mem_gnt_i) SHALL push the winner ID into an in-order owner FIFO of depth MAX_OUTSTANDING.
REQ-008 When the FIFO is full, mem_req_o and both gnts SHALL be 0, even if mem_rvalid_i pops the same cycle.
REQ-009 mem_rvalid_i SHALL pop the FIFO head and route rvalid to that owner in the same cycle; rdata SHALL pass to both hosts, with only the owner's rvalid high.
REQ-010 Simultaneous push and pop when not full SHALL leave occupancy unchanged and preserve order.
REQ-011 mem_rvalid_i with an empty FIFO SHALL be dropped (no host rvalid) and set err_o until reset.
REQ-012 Occupancy counter arithmetic SHALL be ceil(log2(MAX_OUTSTANDING+1)) bits; pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-013 While rst_ni=0 (asynchronously): FIFO empty, lock cleared, round-robin pointer favours dmem, err_o=0; with no requests all outputs SHALL be 0.
REQ-014 Reset mid-transaction SHALL discard outstanding owners; a late mem_rvalid_i after reset SHALL set err_o per REQ-011.

Configuration
REQ-015 With macro LUCID64_ARB_ROUND_ROBIN_EN defined, contention SHALL be resolved round-robin: the pointer moves to the other host after each grant to the favoured host.
REQ-016 Without LUCID64_ARB_ROUND_ROBIN_EN, dmem SHALL always win contention (fixed priority) and no pointer state SHALL exist.

Structure
REQ-017 Host-ID encoding (IMEM=0, DMEM=1) and default be constant SHALL live in the shared Lucid64 header.
REQ-018 The owner FIFO SHALL be the sub-module arb_owner_fifo (push, pop, full, empty, head ID).

Verification
REQ-019 imem_req only, addr 0x8000_0000, gnt same cycle, rvalid 2 cycles later, rdata 0x13 -> imem_gnt_o=1 that cycle, imem_rvalid_o=1 with rdata 0x13, dmem_rvalid_o=0.
REQ-020 Both request, fixed priority, gnt immediate -> dmem granted first, imem next cycle; rvalids returned in order D then I.
REQ-021 Both request continuously, LUCID64_ARB_ROUND_ROBIN_EN, 4 grants -> grant order D,I,D,I.
REQ-022 imem_req, mem_gnt_i held 0 for 3 cycles, dmem_req raised cycle 1 -> mem_addr_o stays imem addr until gnt, then dmem wins.
REQ-023 MAX_OUTSTANDING=2, two grants without rvalid -> mem_req_o=0 on third request until one rvalid, then resumes.
REQ-024 mem_rvalid_i pulse with empty FIFO -> no host rvalid, err_o=1 held until rst_ni low.
